// File: rtl/aes_display_pkg.sv
// Shared types and sizing for the AES state byte scanner display stage.
package aes_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    HOLD
  } scanState_t;

  localparam int NUM_BYTES = 16;
  localparam int BCD_ITERS = 8;
  localparam int IDX_W     = $clog2(NUM_BYTES);
  localparam int ITER_W    = $clog2(BCD_ITERS);

  // Hold counter width; a one-cycle hold still needs a 1-bit counter.
  function automatic int holdCntWidth(int holdCycles);
    return (holdCycles > 1) ? $clog2(holdCycles) : 1;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration on the {hunds,tens,units,bin} register:
// add 3 to every BCD nibble >= 5, then shift the whole register left by 1.
module bcd_dabble_step (
  input  logic [19:0] shiftReg,
  output logic [19:0] stepped
);

  logic [19:0] fixed;

  // Correct each of the three BCD nibbles, then shift.
  always_comb begin
    fixed = shiftReg;
    for (int d = 0; d < 3; d++) begin
      if (shiftReg[8+4*d +: 4] >= 4'd5)
        fixed[8+4*d +: 4] = shiftReg[8+4*d +: 4] + 4'd3;
    end
    stepped = fixed << 1;
  end

endmodule

// File: rtl/aes_byte_scanner.sv
// Walks a captured 128-bit AES state byte by byte onto a three-digit display.
// Each byte is converted to BCD with an 8-step iterative double-dabble and
// held for HOLD_CYCLES enabled cycles; units/tens/hunds drive the BCDtoSSD
// decoders directly. The previous digits stay up during each conversion so
// the display never blanks.
module aes_byte_scanner
  import aes_display_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         load,
  input  logic [0:127] state_in,
  output logic [3:0]   units,
  output logic [3:0]   tens,
  output logic [3:0]   hunds,
  output logic [3:0]   byte_index,
  output logic         valid,
  output logic         busy
);

  localparam int               CNT_W     = holdCntWidth(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(BCD_ITERS - 1);

  scanState_t        state, nextState;
  logic [0:127]      snapshot;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idxNext;
  logic [ITER_W-1:0] iter;
  logic [CNT_W-1:0]  holdCnt;
  logic [19:0]       dabbleReg;
  logic [19:0]       dabbleNext;
  logic              convDone;
  logic              holdDone;

  bcd_dabble_step uStep (
    .shiftReg (dabbleReg),
    .stepped  (dabbleNext)
  );

  // Byte index wraps 15 -> 0 naturally in IDX_W bits.
  assign idxNext  = idx + 1'b1;
  assign convDone = (state == CONVERT) && (iter == ITER_LAST);
  assign holdDone = (state == HOLD) && enable && (holdCnt == HOLD_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state and busy; load overrides every other transition.
  always_comb begin
    nextState = state;
    busy      = 1'b0;
    case (state)
      IDLE:    nextState = IDLE;
      CONVERT: begin
        busy = 1'b1;
        if (convDone) nextState = HOLD;
      end
      HOLD:    if (holdDone) nextState = CONVERT;
      default: nextState = IDLE;
    endcase
    if (load) nextState = CONVERT;
  end

  // Snapshot capture, iterative conversion, hold timing and display registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      snapshot   <= '0;
      idx        <= '0;
      iter       <= '0;
      holdCnt    <= '0;
      dabbleReg  <= '0;
      units      <= '0;
      tens       <= '0;
      hunds      <= '0;
      byte_index <= '0;
      valid      <= 1'b0;
    end else if (load) begin
      snapshot  <= state_in;
      idx       <= '0;
      iter      <= '0;
      valid     <= 1'b0;
      dabbleReg <= {12'b0, state_in[0:7]};
    end else begin
      case (state)
        CONVERT: begin
          dabbleReg <= dabbleNext;
          iter      <= iter + 1'b1;
          if (convDone) begin
            hunds      <= dabbleNext[19:16];
            tens       <= dabbleNext[15:12];
            units      <= dabbleNext[11:8];
            byte_index <= idx;
            valid      <= 1'b1;
            holdCnt    <= '0;
          end
        end
        HOLD: begin
          if (enable) begin
            if (holdCnt == HOLD_LAST) begin
              idx       <= idxNext;
              iter      <= '0;
              dabbleReg <= {12'b0, snapshot[{idxNext, 3'b000} +: 8]};
            end else begin
              holdCnt <= holdCnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
